// File: rtl/uart_retrans_tx.sv
// Even-parity UART transmitter with ack/nack-driven retransmission and a retry limit.
// Optional build macro UART_TX_ERR_INJECT_EN adds inject_err to corrupt the first parity bit.
module uart_retrans_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       send,
`ifdef UART_TX_ERR_INJECT_EN
    input  logic       inject_err,
`endif
    input  logic       nack,
    input  logic       ack,
    output logic       signal,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [4:0] retry_count
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] BitLast   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TimerLast = TW'(ACK_TIMEOUT - 1);
    localparam logic [4:0]    RetryMax  = 5'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWait
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    retry_q, retry_d;
    logic          signal_q, signal_d;
    logic          inj_q, inj_d;
    logic          inject_sample;
    logic          bit_end;
    logic          resend_req;

`ifdef UART_TX_ERR_INJECT_EN
    assign inject_sample = inject_err;
`else
    assign inject_sample = 1'b0;
`endif

    assign bit_end    = (baud_q == BitLast);
    assign resend_req = nack || (timer_q == TimerLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            data_q   <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            timer_q  <= '0;
            retry_q  <= '0;
            signal_q <= 1'b0;
            inj_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            signal_q <= signal_d;
            inj_q    <= inj_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        timer_d = timer_q;
        retry_d = retry_q;
        inj_d   = inj_q;
        done    = 1'b0;
        fail    = 1'b0;

        // Baud counter runs in every line-driving state and restarts on each bit boundary.
        if (state_q != StIdle && state_q != StWait) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (send) begin
                    state_d = StStart;
                    data_d  = data_in;
                    retry_d = '0;
                    baud_d  = '0;
                    inj_d   = inject_sample;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // nack has priority over a simultaneous ack.
                if (resend_req) begin
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + 5'd1;
                        state_d = StStart;
                        baud_d  = '0;
                        inj_d   = 1'b0;
                    end else begin
                        fail    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (ack) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line is registered: drive the value belonging to the state being entered.
    always_comb begin
        signal_d = 1'b0;
        unique case (state_d)
            StStart:  signal_d = 1'b1;
            StData:   signal_d = data_d[bit_d];
            StParity: signal_d = (^data_d) ^ inj_d;
            StStop:   signal_d = 1'b1;
            default:  signal_d = 1'b0;
        endcase
    end

    assign signal      = signal_q;
    assign busy        = (state_q != StIdle);
    assign retry_count = retry_q;

endmodule
